// File: rtl/coreriscv_axi4_locking_demux_pkg.sv
`default_nettype none
// ============================================================================
// coreriscv_axi4_locking_demux_pkg : shared types and constants for the
// Grant response demux.                          Rev 1.0
// ============================================================================
package coreriscv_axi4_locking_demux_pkg;

  localparam int TL_BEATS = 8;
  localparam int DST_W    = 2;
  localparam int BEAT_W   = 3;
  localparam int DATA_W   = 64;
  localparam int MXID_W   = 4;
  localparam int GTYPE_W  = 4;

  localparam logic [GTYPE_W-1:0] GRANT_MB_GTYPE = 4'h4;

  localparam logic [0:0] LOCK_IDLE   = 1'b0;
  localparam logic [0:0] LOCK_LOCKED = 1'b1;

  typedef struct packed {
    logic [DST_W-1:0]   header_src;
    logic [DST_W-1:0]   header_dst;
    logic [BEAT_W-1:0]  payload_addr_beat;
    logic               payload_client_xact_id;
    logic [MXID_W-1:0]  payload_manager_xact_id;
    logic               payload_is_builtin_type;
    logic [GTYPE_W-1:0] payload_g_type;
    logic [DATA_W-1:0]  payload_data;
  } grant_t;

  function automatic logic is_multibeat(input grant_t g, input logic [GTYPE_W-1:0] mb_gtype);
    return g.payload_is_builtin_type && (g.payload_g_type == mb_gtype);
  endfunction

endpackage
`default_nettype wire

// File: rtl/coreriscv_axi4_locking_demux_if.sv
`default_nettype none
// ============================================================================
// coreriscv_axi4_locking_demux_if : Grant input stream, per-client outputs
// and lock status.                               Rev 1.0
// ============================================================================
interface coreriscv_axi4_locking_demux_if #(
  parameter int N_OUT = 4
);
  import coreriscv_axi4_locking_demux_pkg::*;

  logic             io_in_ready;
  logic             io_in_valid;
  grant_t           io_in_bits;
  logic [N_OUT-1:0] io_out_valid;
  logic [N_OUT-1:0] io_out_ready;
  grant_t           io_out_bits [N_OUT];
  logic             io_locked;
  logic             io_dst_err;

  modport master (
    output io_in_valid, io_in_bits, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits, io_locked, io_dst_err
  );

  modport slave (
    input  io_in_valid, io_in_bits, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits, io_locked, io_dst_err
  );

endinterface
`default_nettype wire

// File: rtl/coreriscv_axi4_grant_beat_lock.sv
`default_nettype none
// ============================================================================
// coreriscv_axi4_grant_beat_lock : route lock for multi-beat Grants, counted
// on accepted input beats.                       Rev 1.0
// ============================================================================
module coreriscv_axi4_grant_beat_lock
  import coreriscv_axi4_locking_demux_pkg::*;
#(
  parameter int BEATS = TL_BEATS
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_fire,
  input  wire logic             i_is_mb,
  input  wire logic [DST_W-1:0] i_dst,
  output logic                  o_locked,
  output logic [DST_W-1:0]      o_lock_dst,
  output logic                  o_dst_err
);

  localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [DST_W-1:0]  r_lock_dst;
  logic              r_dst_err;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= LOCK_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOCK_IDLE:   if (i_fire && i_is_mb) w_state_nxt = LOCK_LOCKED;
      LOCK_LOCKED: if (i_fire && (r_beat_cnt == c_LAST_BEAT)) w_state_nxt = LOCK_IDLE;
      default:     w_state_nxt = LOCK_IDLE;
    endcase
  end

  always_comb begin
    o_locked   = (r_state == LOCK_LOCKED);
    o_lock_dst = r_lock_dst;
    o_dst_err  = r_dst_err;
  end

  // A mismatching beat inside a block is flagged but still follows the lock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_beat_cnt <= '0;
      r_lock_dst <= '0;
      r_dst_err  <= 1'b0;
    end else if (i_fire) begin
      if (r_state == LOCK_IDLE) begin
        if (i_is_mb) begin
          r_lock_dst <= i_dst;
          r_beat_cnt <= BEAT_W'(1);
        end
      end else begin
        r_beat_cnt <= (r_beat_cnt == c_LAST_BEAT) ? '0 : r_beat_cnt + BEAT_W'(1);
        if (i_dst != r_lock_dst) r_dst_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/coreriscv_axi4_locking_demux.sv
`default_nettype none
// ============================================================================
// coreriscv_axi4_locking_demux : 1:4 Grant router with one-entry output
// register and multi-beat route lock.            Rev 1.0
// ============================================================================
module coreriscv_axi4_locking_demux
  import coreriscv_axi4_locking_demux_pkg::*;
#(
  parameter int                 N_OUT    = 4,
  parameter int                 BEATS    = TL_BEATS,
  parameter logic [GTYPE_W-1:0] MB_GTYPE = GRANT_MB_GTYPE
) (
  input wire logic                      clk,
  input wire logic                      reset,
  coreriscv_axi4_locking_demux_if.slave bus
);

  logic             r_full;
  logic [DST_W-1:0] r_route;
  grant_t           r_data;

  logic             w_out_fire;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_is_mb;
  logic             w_locked;
  logic [DST_W-1:0] w_lock_dst;
  logic             w_dst_err;

  // Ready depends only on the held beat, never on io_in_valid.
  assign w_out_fire = r_full && bus.io_out_ready[r_route];
  assign w_in_ready = !r_full || w_out_fire;
  assign w_in_fire  = bus.io_in_valid && w_in_ready;
  assign w_is_mb    = is_multibeat(bus.io_in_bits, MB_GTYPE);

  coreriscv_axi4_grant_beat_lock #(
    .BEATS (BEATS)
  ) u_lock (
    .clk        (clk),
    .reset      (reset),
    .i_fire     (w_in_fire),
    .i_is_mb    (w_is_mb),
    .i_dst      (bus.io_in_bits.header_dst),
    .o_locked   (w_locked),
    .o_lock_dst (w_lock_dst),
    .o_dst_err  (w_dst_err)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_full  <= 1'b0;
      r_route <= '0;
    end else if (w_in_fire) begin
      r_full  <= 1'b1;
      r_route <= w_locked ? w_lock_dst : bus.io_in_bits.header_dst;
    end else if (w_out_fire) begin
      r_full  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) r_data <= bus.io_in_bits;
  end

  assign bus.io_in_ready = w_in_ready;
  assign bus.io_locked   = w_locked;
  assign bus.io_dst_err  = w_dst_err;

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign bus.io_out_valid[k] = r_full && (r_route == DST_W'(k));
    assign bus.io_out_bits[k]  = r_data;
  end

endmodule
`default_nettype wire
